// File: rtl/pe_drain_pkg.sv
// Shared types and default geometry for the PE result drain path.
package pe_pkg;

    typedef enum logic [0:0] {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } drain_state_t;

    localparam int PE_OUTWIDTH = 32;
    localparam int PE_ROWS     = 8;
    localparam int PE_COLS     = 8;

    // Index width that stays legal (>= 1) for a single-row array.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_drain_cell.sv
// One PE capture slot: result register plus captured flag.
// Optional PE_DRAIN_OVERRUN_EN adds the duplicate-valid pulse output.
module pe_drain_cell
    import pe_pkg::*;
#(
    parameter int OUTWIDTH = PE_OUTWIDTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid,
    input  logic [OUTWIDTH-1:0] res,
    input  logic                clr,
    input  logic                en,
    output logic [OUTWIDTH-1:0] data,
`ifdef PE_DRAIN_OVERRUN_EN
    output logic                dup,
`endif
    output logic                flag
);

    // First valid while enabled wins; later valids never overwrite the slot.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data <= {OUTWIDTH{1'b0}};
            flag <= 1'b0;
        end else if (clr) begin
            flag <= 1'b0;
        end else if (en && valid && !flag) begin
            data <= res;
            flag <= 1'b1;
        end else begin
            flag <= flag;
        end
    end

`ifdef PE_DRAIN_OVERRUN_EN
    assign dup = valid & (flag | ~en);
`endif

endmodule

// File: rtl/pe_drain.sv
// Collects one result per PE, then streams the tile out row by row.
// Optional PE_DRAIN_OVERRUN_EN enables sticky overrun detection.
module pe_drain
    import pe_pkg::*;
#(
    parameter  int ROWS     = PE_ROWS,
    parameter  int COLS     = PE_COLS,
    parameter  int OUTWIDTH = PE_OUTWIDTH,
    localparam int IDXW     = idx_width(ROWS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [OUTWIDTH-1:0] in_res   [0:ROWS*COLS-1],
    input  logic                in_valid [0:ROWS*COLS-1],
    input  logic                clear,
    output logic [OUTWIDTH-1:0] out_row  [0:COLS-1],
    output logic [IDXW-1:0]     out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                overrun
);

    localparam int            NPE      = ROWS * COLS;
    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(ROWS - 1);

    drain_state_t          state_r;
    logic [IDXW-1:0]       row_ptr_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic                  busy_r;

    logic [OUTWIDTH-1:0]   grid_s [0:ROWS-1][0:COLS-1];
    logic [NPE-1:0]        flag_s;
    logic [NPE-1:0]        flag_next_s;
    logic                  all_next_s;
    logic                  en_s;
    logic                  last_accept_s;
    logic                  clr_s;

    assign en_s          = (state_r == CAPTURE);
    assign last_accept_s = (state_r == DRAIN) && out_ready && (row_ptr_r == LAST_ROW);
    assign clr_s         = clear | last_accept_s;

`ifdef PE_DRAIN_OVERRUN_EN
    logic [NPE-1:0]        dup_s;
    logic                  overrun_r;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = c + r * COLS;

            pe_drain_cell #(
                .OUTWIDTH (OUTWIDTH)
            ) u_cell (
                .clk   (clk),
                .rstn  (rstn),
                .valid (in_valid[K]),
                .res   (in_res[K]),
                .clr   (clr_s),
                .en    (en_s),
                .data  (grid_s[r][c]),
`ifdef PE_DRAIN_OVERRUN_EN
                .dup   (dup_s[K]),
`endif
                .flag  (flag_s[K])
            );

            // Mirrors the cell's capture rule so the FSM can switch on the completing edge.
            assign flag_next_s[K] = flag_s[K] | (in_valid[K] & en_s & ~clear);
        end
    end

    assign all_next_s = &flag_next_s;

    // Row select straight from the capture registers; row_ptr is itself registered.
    always_comb begin
        for (int j = 0; j < COLS; j++) begin
            out_row[j] = grid_s[row_ptr_r][j];
        end
    end

    // Capture/drain sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= CAPTURE;
            row_ptr_r   <= {IDXW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else if (clear) begin
            state_r     <= CAPTURE;
            row_ptr_r   <= {IDXW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                CAPTURE: begin
                    if (all_next_s) begin
                        state_r     <= DRAIN;
                        row_ptr_r   <= {IDXW{1'b0}};
                        out_valid_r <= 1'b1;
                        out_last_r  <= (ROWS == 1);
                        busy_r      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_ptr_r == LAST_ROW) begin
                            state_r     <= CAPTURE;
                            row_ptr_r   <= {IDXW{1'b0}};
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            row_ptr_r  <= row_ptr_r + IDXW'(1);
                            out_last_r <= ((row_ptr_r + IDXW'(1)) == LAST_ROW);
                        end
                    end
                end
                default: begin
                    state_r     <= CAPTURE;
                    row_ptr_r   <= {IDXW{1'b0}};
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_DRAIN_OVERRUN_EN
    // Sticky until reset; clear deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r | (|dup_s);
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    assign out_idx   = row_ptr_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain at the default 8x8 geometry.
module tb_pe_drain;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int W    = 32;
    localparam int NPE  = ROWS * COLS;

`ifdef PE_DRAIN_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic           clk;
    logic           rstn;
    logic [W-1:0]   in_res   [0:NPE-1];
    logic           in_valid [0:NPE-1];
    logic           clear;
    logic [W-1:0]   out_row  [0:COLS-1];
    logic [2:0]     out_idx;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;
    logic           overrun;

    int total;
    int bad;

    pe_drain #(.ROWS(ROWS), .COLS(COLS), .OUTWIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_res    (in_res),
        .in_valid  (in_valid),
        .clear     (clear),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_valid();
        for (int k = 0; k < NPE; k++) in_valid[k] = 1'b0;
    endtask

    // All PEs report in one cycle with value base+k; valids drop right after the edge.
    task automatic load_tile(input int base);
        for (int k = 0; k < NPE; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = W'(base + k);
        end
        step();
        no_valid();
    endtask

    // Expects the first beat already presented; out_ready must be high.
    task automatic drain_check(input string tag, input int base);
        for (int r = 0; r < ROWS; r++) begin
            chk({tag, "_valid"}, W'(out_valid), 32'd1);
            chk({tag, "_busy"},  W'(busy),      32'd1);
            chk({tag, "_idx"},   W'(out_idx),   W'(r));
            chk({tag, "_last"},  W'(out_last),  (r == ROWS - 1) ? 32'd1 : 32'd0);
            for (int j = 0; j < COLS; j++) begin
                chk({tag, "_row"}, out_row[j], W'(base + 8 * r + j));
            end
            step();
        end
        chk({tag, "_busy_end"},  W'(busy),      32'd0);
        chk({tag, "_valid_end"}, W'(out_valid), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NPE; k++) in_res[k] = 32'd0;
        no_valid();
        step();
        step();

        // Reset state
        chk("rst_valid",   W'(out_valid), 32'd0);
        chk("rst_busy",    W'(busy),      32'd0);
        chk("rst_idx",     W'(out_idx),   32'd0);
        chk("rst_last",    W'(out_last),  32'd0);
        chk("rst_overrun", W'(overrun),   32'd0);
        chk("rst_row0",    out_row[0],    32'd0);
        chk("rst_row7",    out_row[7],    32'd0);
        rstn = 1'b1;
        step();

        // Whole tile in one cycle, ready held high: 8 back-to-back beats
        out_ready = 1'b1;
        load_tile(100);
        drain_check("burst", 100);

        // Diagonal wavefront: PE (i,j) reports value k at cycle i+j
        for (int t = 0; t <= 14; t++) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    in_valid[j + i * COLS] = ((i + j) == t);
                    in_res[j + i * COLS]   = W'(j + i * COLS);
                end
            end
            step();
            no_valid();
            chk("wave_busy", W'(busy), (t == 14) ? 32'd1 : 32'd0);
        end
        drain_check("wave", 0);
        chk("wave_overrun", W'(overrun), 32'd0);

        // Partial tile never drains
        in_valid[5] = 1'b1;
        in_res[5]   = 32'd55;
        step();
        no_valid();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("partial_busy", W'(busy), 32'd0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Duplicate on PE0 (5 then 9) followed by backpressure on beat 0
        out_ready   = 1'b0;
        in_valid[0] = 1'b1;
        in_res[0]   = 32'd5;
        step();
        chk("dup_busy0", W'(busy), 32'd0);
        for (int k = 0; k < NPE; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = W'(k);
        end
        in_res[0] = 32'd9;
        step();
        no_valid();
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", W'(out_valid), 32'd1);
            chk("bp_idx",   W'(out_idx),   32'd0);
            chk("bp_row0",  out_row[0],    32'd5);
            chk("bp_row7",  out_row[7],    32'd7);
            step();
        end
        chk("dup_overrun", W'(overrun), W'(OVR_EXP));
        out_ready = 1'b1;
        step();
        chk("bp_idx1",  W'(out_idx), 32'd1);
        chk("bp_row1",  out_row[0],  32'd8);
        step();
        chk("bp_idx2",  W'(out_idx), 32'd2);

        // Clear mid-drain after beat 1 was accepted
        out_ready = 1'b0;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid",   W'(out_valid), 32'd0);
        chk("clr_busy",    W'(busy),      32'd0);
        chk("clr_idx",     W'(out_idx),   32'd0);
        chk("clr_overrun", W'(overrun),   W'(OVR_EXP));
        step();
        chk("clr_idle", W'(busy), 32'd0);
        out_ready = 1'b1;
        load_tile(200);
        drain_check("after_clr", 200);

        // One-cycle reset while a tile sits in DRAIN
        out_ready = 1'b0;
        load_tile(300);
        chk("pre_rst_busy", W'(busy), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mrst_valid",   W'(out_valid), 32'd0);
        chk("mrst_busy",    W'(busy),      32'd0);
        chk("mrst_idx",     W'(out_idx),   32'd0);
        chk("mrst_last",    W'(out_last),  32'd0);
        chk("mrst_overrun", W'(overrun),   32'd0);
        chk("mrst_row0",    out_row[0],    32'd0);
        step();
        chk("mrst_idle", W'(busy), 32'd0);
        out_ready = 1'b1;
        load_tile(400);
        drain_check("after_rst", 400);
        chk("final_overrun", W'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
